// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and sizing helpers for the PLL reset sequencer
package pll_seq_pkg;
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT} state_e;
  localparam int LOSS_W = 8;
  function automatic int cnt_w(input int lim);
    return lim > 1 ? $clog2(lim) : 1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s2_q, s1_q} <= '0;
    else     {s2_q, s1_q} <= {s1_q, d_i};
  assign q_o = s2_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses PLL reset, waits for stable lock with timeout/retry, raises ready or fault
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               pll_locked,
  input  logic                               clear_fault,
  output logic                               pll_rst,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [LOSS_W-1:0]                  loss_count
);
  localparam int RW = cnt_w(RST_PULSE_CYCLES);
  localparam int TW = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int SW = cnt_w(LOCK_STABLE_CYCLES);
  localparam int CW = $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] R_LAST = RW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(MAX_RETRIES);
  state_e              state_q, state_d;
  logic [RW-1:0]       rcnt_q, rcnt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [SW-1:0]       scnt_q, scnt_d;
  logic [CW-1:0]       retry_q, retry_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic                pll_rst_q, ready_q, fault_q;
  logic                locked_s;
  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (locked_s)
  );
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      RESET_PLL:
        if (rcnt_q == R_LAST) begin
          state_d = WAIT_LOCK;
          tcnt_d  = '0;
        end else rcnt_d = rcnt_q + 1'b1;
      // lock wins over a timeout landing in the same cycle
      WAIT_LOCK:
        if (locked_s) begin
          state_d = STABILIZE;
          scnt_d  = '0;
        end else if (tcnt_q == T_LAST) begin
          state_d = retry_q == C_MAX ? FAULT : RESET_PLL;
          retry_d = retry_q == C_MAX ? retry_q : retry_q + 1'b1;
          rcnt_d  = '0;
        end else tcnt_d = tcnt_q + 1'b1;
      STABILIZE:
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          tcnt_d  = '0;
          scnt_d  = '0;
        end else if (scnt_q == S_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end else scnt_d = scnt_q + 1'b1;
      RUN:
        if (!locked_s) begin
          state_d = RESET_PLL;
          rcnt_d  = '0;
          loss_d  = &loss_q ? loss_q : loss_q + 1'b1;
        end
      FAULT:
        if (clear_fault) begin
          state_d = RESET_PLL;
          rcnt_d  = '0;
          retry_d = '0;
        end
      default: state_d = RESET_PLL;
    endcase
  end
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      state_q   <= RESET_PLL;
      rcnt_q    <= '0;
      tcnt_q    <= '0;
      scnt_q    <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      tcnt_q    <= tcnt_d;
      scnt_q    <= scnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= state_d == RESET_PLL || state_d == FAULT;
      ready_q   <= state_d == RUN;
      fault_q   <= state_d == FAULT;
    end
  assign pll_rst     = pll_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scoreboard of expected output transitions for the PLL reset sequencer
module tb_pll_reset_sequencer;
  localparam int SIG_RST = 0, SIG_RDY = 1, SIG_FLT = 2;
  logic refclk = 0, rst = 1, pll_locked = 0, clear_fault = 0;
  logic pll_rst, ready, fault;
  logic [1:0] retry_count;
  logic [7:0] loss_count;
  int cyc = 0, n_vec = 0, n_err = 0;
  logic p_rst = 1, p_rdy = 0, p_flt = 0;
  bit mon_en = 0;
  typedef struct {int sig; int val; int cyc;} ev_t;
  ev_t q[$];
  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32), .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .clear_fault(clear_fault),
    .pll_rst(pll_rst), .ready(ready), .fault(fault),
    .retry_count(retry_count), .loss_count(loss_count)
  );
  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= rst ? 0 : cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic push(input int s, input int v, input int c);
    q.push_back('{s, v, c});
  endtask
  // events are coded sig*1e6 + val*1e5 + cycle
  task automatic see(input int s, input logic v);
    int got = s * 1000000 + int'(v) * 100000 + cyc;
    if (q.size() == 0) chk("evt_unexpected", got, -1);
    else begin
      ev_t e = q.pop_front();
      chk("evt", got, e.sig * 1000000 + e.val * 100000 + e.cyc);
    end
  endtask
  always @(negedge refclk) begin
    if (mon_en) begin
      if (pll_rst !== p_rst) see(SIG_RST, pll_rst);
      if (ready !== p_rdy) see(SIG_RDY, ready);
      if (fault !== p_flt) see(SIG_FLT, fault);
    end
    p_rst <= pll_rst;
    p_rdy <= ready;
    p_flt <= fault;
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask
  task automatic step_to(input int t);
    while (cyc < t) step(1);
  endtask
  task automatic apply_reset(input logic lock);
    mon_en = 0;
    rst = 1;
    pll_locked = lock;
    clear_fault = 0;
    q.delete();
    repeat (2) @(negedge refclk);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry_count, 0);
    chk("rst_loss", loss_count, 0);
    @(posedge refclk);
    #1;
    rst = 0;
    mon_en = 1;
    push(SIG_RST, 0, 4);
  endtask
  initial begin
    int c;
    apply_reset(1'b0);
    step_to(10);
    pll_locked = 1;
    push(SIG_RDY, 1, cyc + 11);
    step_to(25);
    chk("nom_ready", ready, 1);
    chk("nom_fault", fault, 0);
    chk("nom_retry", retry_count, 0);
    chk("nom_pending", q.size(), 0);
    for (int i = 1; i <= 300; i++) begin
      c = cyc;
      pll_locked = 0;
      push(SIG_RST, 1, c + 3);
      push(SIG_RDY, 0, c + 3);
      push(SIG_RST, 0, c + 7);
      step(4);
      pll_locked = 1;
      push(SIG_RDY, 1, c + 16);
      step(13);
      chk("loss_count", loss_count, i > 255 ? 255 : i);
      if (i == 1) chk("loss_retry", retry_count, 0);
    end
    chk("loss_pending", q.size(), 0);
    step(3);
    #2;
    mon_en = 0;
    rst = 1;
    #1;
    chk("arst_ready", ready, 0);
    chk("arst_pll_rst", pll_rst, 1);
    chk("arst_loss", loss_count, 0);
    chk("arst_fault", fault, 0);
    apply_reset(1'b1);
    push(SIG_RDY, 1, 13);
    step_to(16);
    chk("restart_ready", ready, 1);
    chk("restart_pending", q.size(), 0);
    apply_reset(1'b0);
    push(SIG_RST, 1, 36);
    push(SIG_RST, 0, 40);
    push(SIG_RST, 1, 72);
    push(SIG_RST, 0, 76);
    push(SIG_RST, 1, 108);
    push(SIG_FLT, 1, 108);
    step_to(20);
    clear_fault = 1;
    step(1);
    clear_fault = 0;
    step_to(30);
    chk("to_retry0", retry_count, 0);
    step_to(45);
    chk("to_retry1", retry_count, 1);
    step_to(80);
    chk("to_retry2", retry_count, 2);
    step_to(112);
    chk("flt_fault", fault, 1);
    chk("flt_pll_rst", pll_rst, 1);
    chk("flt_ready", ready, 0);
    chk("flt_retry", retry_count, 2);
    step_to(115);
    clear_fault = 1;
    push(SIG_FLT, 0, 116);
    push(SIG_RST, 0, 120);
    step(1);
    clear_fault = 0;
    chk("clr_retry", retry_count, 0);
    step_to(125);
    chk("clr_pending", q.size(), 0);
    apply_reset(1'b0);
    step_to(10);
    pll_locked = 1;
    step(5);
    pll_locked = 0;
    step(1);
    pll_locked = 1;
    push(SIG_RDY, 1, cyc + 11);
    step_to(22);
    chk("glitch_no_ready", ready, 0);
    step_to(30);
    chk("glitch_ready", ready, 1);
    chk("glitch_pending", q.size(), 0);
    apply_reset(1'b0);
    step_to(33);
    pll_locked = 1;
    push(SIG_RDY, 1, 44);
    step_to(40);
    chk("edge_retry", retry_count, 0);
    chk("edge_pll_rst", pll_rst, 0);
    step_to(48);
    chk("edge_ready", ready, 1);
    chk("edge_pending", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RST_PULSE_CYCLES, default 16: number of cycles pll_rst is held high per PLL reset attempt (minimum 1).
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive cycles of synchronized lock required before ready is asserted.
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 50000: maximum cycles spent waiting for lock per attempt (1 ms at 50 MHz).
REQ-004 Parameter MAX_RETRIES, default 3: number of re-attempts after the first timeout before the block declares FAULT.
REQ-005 refclk  in  1  sole clock (50 MHz PLL reference); every register is in this domain.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 pll_locked  in  1  raw PLL lock flag, asynchronous to refclk.
REQ-008 clear_fault  in  1  single-cycle request to leave FAULT; ignored in every other state.
REQ-009 pll_rst  out  1  registered reset to the PLL.
REQ-010 ready  out  1  registered; high only in RUN, and used as the release for downstream video reset synchronizers.
REQ-011 fault  out  1  registered; high only in FAULT.
REQ-012 retry_count  out  $clog2(MAX_RETRIES+1)  timeouts taken in the current bring-up sequence.
REQ-013 loss_count  out  8  count of lock losses while in RUN; saturates at 255.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer (locked_s) before any use; this adds 2 cycles of latency.
REQ-015 The FSM SHALL have five states: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT.
REQ-016 RESET_PLL: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK with the timeout counter at 0.
REQ-017 WAIT_LOCK: pll_rst=0; the timeout counter increments each cycle.
- If locked_s=1, go to STABILIZE.
- Else, when the counter reaches LOCK_TIMEOUT_CYCLES-1 and retry_count<MAX_RETRIES, increment retry_count and go to RESET_PLL.
- Else, when the counter reaches LOCK_TIMEOUT_CYCLES-1 and retry_count=MAX_RETRIES, go to FAULT.
REQ-018 If locked_s=1 in the timeout cycle of WAIT_LOCK, lock SHALL take priority over the timeout.
REQ-019 STABILIZE: the stable counter increments while locked_s=1.
- If locked_s=0, clear the counter and return to WAIT_LOCK; the timeout counter restarts at 0 and retry_count is unchanged.
- When the counter reaches LOCK_STABLE_CYCLES-1, go to RUN and clear retry_count.
REQ-020 RUN: ready=1. On the first cycle with locked_s=0, go to RESET_PLL and increment loss_count (saturating); retry_count stays 0.
REQ-021 ready SHALL fall in the cycle RESET_PLL is entered, which is 1 cycle after locked_s is sampled low and 3 cycles after a pll_locked fall.
REQ-022 FAULT: pll_rst=1, fault=1, ready=0. When clear_fault=1, clear retry_count and go to RESET_PLL.
REQ-023 All counters SHALL be sized by $clog2 of their limit and SHALL never wrap; each is cleared on every state entry that uses it.
REQ-024 ready, fault and pll_rst SHALL be decoded from the next-state value and registered, so none of them glitches.

Reset
REQ-025 rst SHALL asynchronously force state=RESET_PLL, pll_rst=1, ready=0, fault=0, retry_count=0, loss_count=0, synchronizer flops=0 and all counters=0.
REQ-026 rst asserted in any state, including mid-RUN and mid-STABILIZE, SHALL abort the sequence immediately; after release the sequence restarts with a full RST_PULSE_CYCLES pulse.
REQ-027 Reset release SHALL be sampled on refclk; the first counted cycle is the first refclk edge with rst=0.

Structure
REQ-028 Shared package pll_seq_pkg SHALL hold the state enum typedef and the loss_count width constant.
REQ-029 The lock synchronizer SHALL be the sub-module sync_2ff (reusable, reset to 0).
REQ-030 The FSM, counters and output registers SHALL be in one always_ff block, with a separate always_comb block for next-state logic.

Verification
Bench parameters: RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
REQ-031 Nominal bring-up: pll_locked rises 10 cycles after rst release -> pll_rst high for exactly 4 cycles, then ready=1 after the 2-cycle sync plus 8 stable cycles; fault=0, retry_count=0.
REQ-032 Lock never asserts -> 3 pll_rst pulses of 4 cycles each, 32 cycles apart after each pulse; retry_count steps 0,1,2; FAULT is entered with fault=1 and pll_rst=1 held; a clear_fault pulse -> new pulse and retry_count=0.
REQ-033 Lock glitch: pll_locked high 5 cycles, then low 1 cycle, during STABILIZE -> return to WAIT_LOCK, no ready pulse, and ready only after a later 8 consecutive stable cycles.
REQ-034 Lock loss in RUN: pll_locked falls -> ready=0 exactly 3 cycles later, loss_count=1, a new 4-cycle pll_rst pulse; 300 forced losses -> loss_count=255.
REQ-035 Boundary and reset: locked_s rises in the exact timeout cycle -> STABILIZE, not a retry; rst asserted mid-RUN -> ready=0 and pll_rst=1 asynchronously, before the next edge.
